// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU opcodes and
// the arbiter FSM state type.
package alu_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;
  localparam int SEL_W    = 3;

  localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [SEL_W-1:0] ALU_MUL = 3'b010;
  localparam logic [SEL_W-1:0] ALU_NEQ = 3'b011;
  localparam logic [SEL_W-1:0] ALU_AND = 3'b100;
  localparam logic [SEL_W-1:0] ALU_OR  = 3'b101;
  localparam logic [SEL_W-1:0] ALU_XOR = 3'b110;
  localparam logic [SEL_W-1:0] ALU_NOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner selection for the ALU arbiter.
// ALU_ARB_RR_EN defined: round-robin, search starts one past ptr.
// ALU_ARB_RR_EN undefined: fixed priority, lowest valid index wins, ptr ignored.
module alu_arb_pick
  import alu_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

`ifdef ALU_ARB_RR_EN
  int             cand;
  logic [IDW-1:0] cidx;
  logic           found;

  // Rotate the search so the requester after the last winner is tried first.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      cidx = cand[IDW-1:0];
      if (!found && req_valid[cidx]) begin
        grant[cidx] = 1'b1;
        idx         = cidx;
        found       = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the top down so the lowest valid index overrides the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NREQ requesters. One op is in flight at a
// time: grant -> EXEC (ALU registers) -> CAPT (result captured) -> RESP
// (held until rsp_ready). Build with ALU_ARB_RR_EN for round-robin
// selection; the default build uses fixed lowest-index priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*W-1:0]     req_A,
  input  logic [NREQ*W-1:0]     req_B,
  input  logic [NREQ*SEL_W-1:0] req_sel,
  output logic [W-1:0]          alu_A,
  output logic [W-1:0]          alu_B,
  output logic [SEL_W-1:0]      alu_sel,
  input  logic [W-1:0]          alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [W-1:0]          rsp_data,
  output logic                  busy
);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  win_id_p0;
  logic            grant_en;

  alu_arb_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .idx       (pick_idx)
  );

  assign grant_en = (state == IDLE) && (|req_valid);

`ifdef ALU_ARB_RR_EN
  // Remember the last winner so the next search begins just after it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rr_ptr <= IDW'(NREQ - 1);
    end else if (grant_en) begin
      rr_ptr <= pick_idx;
    end
  end
`else
  assign rr_ptr = IDW'(NREQ - 1);
`endif

  // FSM state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; grants are only offered while idle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = pick_grant;
        if (grant_en) state_nxt = EXEC;
      end
      EXEC: state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: latch the winner's operands toward the ALU on the grant edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      alu_A     <= '0;
      alu_B     <= '0;
      alu_sel   <= '0;
      win_id_p0 <= '0;
    end else if (grant_en) begin
      alu_A     <= req_A[int'(pick_idx)*W +: W];
      alu_B     <= req_B[int'(pick_idx)*W +: W];
      alu_sel   <= req_sel[int'(pick_idx)*SEL_W +: SEL_W];
      win_id_p0 <= pick_idx;
    end
  end

  // Stage p2: capture the ALU result and hold it until the response is accepted.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (state == CAPT) begin
      rsp_valid <= 1'b1;
      rsp_id    <= win_id_p0;
      rsp_data  <= alu_out;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
